// File: rtl/rv32_alu_arbiter.sv
// rv32_alu_arbiter: round-robin sharing of one rv32_alu among NUM_REQ requesters
//   Operands are registered before the ALU and the result after it; one op is in flight at a time
//   (IDLE grant -> EXEC -> RESP).
//   Ports:
//     clk, rst                        clock, asynchronous active-high reset
//     req_valid_i / req_ready_o       per-requester handshake; ready is a one-hot grant in IDLE
//     req_op_i, req_a_i, req_b_i      per-requester operation and operands
//     alu_op_o, alu_a_o, alu_b_o      registered operands driven into the ALU
//     alu_result_i, alu_zero_i        ALU outputs, sampled at the end of EXEC
//     rsp_valid_o / rsp_ready_i       response handshake
//     rsp_id_o, rsp_result_o, rsp_zero_o   response payload; holds after rsp_valid_o drops
//     perf_stall_o                    only with RV32_ALU_ARB_PERF_EN: saturating per-requester stall counters
package pkg_rv32_types;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
    } alu_op_e;
endpackage

module rv32_alu_arbiter
    import pkg_rv32_types::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  alu_op_e                       req_op_i [NUM_REQ],
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b_i,
    output alu_op_e                       alu_op_o,
    output logic [XLEN-1:0]               alu_a_o,
    output logic [XLEN-1:0]               alu_b_o,
    input  logic [XLEN-1:0]               alu_result_i,
    input  logic                          alu_zero_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [IDW-1:0]                rsp_id_o,
    output logic [XLEN-1:0]               rsp_result_o,
    output logic                          rsp_zero_o
`ifdef RV32_ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][15:0]      perf_stall_o
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    alu_op_e             op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]     rsp_result_q, rsp_result_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_zero_q, rsp_zero_d;

    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;
    logic [IDW-1:0]       off, win;
    logic [IDW:0]         sum;

    // Rotating the doubled request vector by rr_ptr puts the highest-priority requester at bit 0.
    assign dbl = {req_valid_i, req_valid_i} >> rr_ptr_q;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
    end

    assign sum = {1'b0, rr_ptr_q} + {1'b0, off};
    assign win = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);

    assign req_ready_o = (state_q == IDLE && found) ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: if (found) begin
                op_d     = req_op_i[win];
                a_d      = req_a_i[win];
                b_d      = req_b_i[win];
                id_d     = win;
                rr_ptr_d = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                rsp_result_d = alu_result_i;
                rsp_zero_d   = alu_zero_i;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: if (rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_q         <= ALU_ADD;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_op_o     = op_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;

`ifdef RV32_ALU_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] perf_q, perf_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_d[i] = (req_valid_i[i] && !req_ready_o[i] && perf_q[i] != 16'hFFFF) ? perf_q[i] + 16'd1 : perf_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_o = perf_q;
`endif
endmodule
